// File: rtl/fetch_ctrl_pkg.sv
// ============================================================================
// Module      : fetch_ctrl_pkg
// Description : Shared fetch-side constants and the fetch state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_ctrl_pkg;

   localparam int                ADDR_W  = 16;
   localparam int                INSTR_W = 16;
   localparam logic [ADDR_W-1:0] PC_INC  = 16'd2;
   localparam logic [3:0]        HALT_OP = 4'hF;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_WAIT   = 3'd1,
      ST_HOLD   = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_HALTED = 3'd4
   } fetch_state_t;

   function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
      return (instr[INSTR_W-1 -: 4] == HALT_OP);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_ctrl_buf.sv
// ============================================================================
// Module      : fetch_buf
// Description : One-entry instruction holding register with load and clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_buf
   import fetch_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_load,
   input  logic               i_clr,
   input  logic [INSTR_W-1:0] i_data,
   output logic [INSTR_W-1:0] o_data,
   output logic               o_valid
);

   logic [INSTR_W-1:0] r_data;
   logic               r_valid;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_data  <= i_data;
         r_valid <= 1'b1;
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module      : fetch_ctrl
// Description : Next-PC and instruction-fetch controller feeding IF/ID.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_ctrl
   import fetch_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_W-1:0]  pc,
   output logic [ADDR_W-1:0]  pc_next,
   output logic               pc_we,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ready,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               stall,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_target,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [ADDR_W-1:0]  if_pc_plus2,
   output logic               halted
);

   fetch_state_t       r_state;
   fetch_state_t       w_state_nxt;
   logic [ADDR_W-1:0]  w_pc_inc;
   logic               w_buf_load;
   logic               w_buf_clr;
   logic               w_buf_valid;
   logic [INSTR_W-1:0] w_buf_data;

   assign w_pc_inc    = pc + PC_INC;
   assign imem_addr   = pc;
   assign if_pc_plus2 = w_pc_inc;

   fetch_buf u_buf (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_buf_load),
      .i_clr   (w_buf_clr),
      .i_data  (imem_data),
      .o_data  (w_buf_data),
      .o_valid (w_buf_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_FETCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      pc_next     = w_pc_inc;
      pc_we       = 1'b0;
      imem_req    = 1'b0;
      if_valid    = 1'b0;
      if_instr    = '0;
      halted      = 1'b0;
      w_buf_load  = 1'b0;
      w_buf_clr   = 1'b0;

      case (r_state)
         ST_FETCH, ST_WAIT: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               if_valid = 1'b1;
               if_instr = imem_data;
               if (stall) begin
                  w_buf_load  = 1'b1;
                  w_state_nxt = ST_HOLD;
               end else if (is_halt(imem_data)) begin
                  // PC stays on the HLT so if_pc_plus2 keeps pointing past it
                  w_state_nxt = ST_HALTED;
               end else begin
                  pc_we       = 1'b1;
                  w_state_nxt = ST_FETCH;
               end
            end else begin
               w_state_nxt = ST_WAIT;
            end
         end
         ST_HOLD: begin
            if_valid = w_buf_valid;
            if_instr = w_buf_data;
            if (!stall) begin
               w_buf_clr = 1'b1;
               if (is_halt(w_buf_data)) begin
                  w_state_nxt = ST_HALTED;
               end else begin
                  pc_we       = 1'b1;
                  w_state_nxt = ST_FETCH;
               end
            end
         end
         ST_DRAIN: begin
            if (imem_ready) begin
               w_state_nxt = ST_FETCH;
            end
         end
         ST_HALTED: begin
            halted = 1'b1;
         end
         default: begin
            w_state_nxt = ST_FETCH;
         end
      endcase

      // An older branch overrides everything younger, including a pending HLT
      if (redirect) begin
         pc_next    = redirect_target;
         pc_we      = 1'b1;
         if_valid   = 1'b0;
         if_instr   = '0;
         w_buf_load = 1'b0;
         w_buf_clr  = 1'b1;
         if ((r_state == ST_WAIT || r_state == ST_DRAIN) && !imem_ready) begin
            w_state_nxt = ST_DRAIN;
         end else begin
            w_state_nxt = ST_FETCH;
         end
      end

      if (rst) begin
         pc_we      = 1'b0;
         imem_req   = 1'b0;
         if_valid   = 1'b0;
         if_instr   = '0;
         halted     = 1'b0;
         w_buf_load = 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Randomized scoreboard bench for fetch_ctrl with a memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;
   import fetch_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] pc;
   logic [15:0] pc_next;
   logic        pc_we;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [15:0] imem_data = 16'h0000;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_target = 16'h0000;
   logic        if_valid;
   logic [15:0] if_instr;
   logic [15:0] if_pc_plus2;
   logic        halted;

   fetch_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .pc              (pc),
      .pc_next         (pc_next),
      .pc_we           (pc_we),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ready      (imem_ready),
      .imem_data       (imem_data),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .if_valid        (if_valid),
      .if_instr        (if_instr),
      .if_pc_plus2     (if_pc_plus2),
      .halted          (halted)
   );

   always #5 clk = ~clk;

   // PC register downstream of the controller
   always @(posedge clk) begin
      if (rst) pc <= 16'h0000;
      else if (pc_we) pc <= pc_next;
   end

   logic [15:0] mem [0:32767];

   function automatic logic [15:0] mem_rd(input logic [15:0] a);
      return mem[a[15:1]];
   endfunction

   // Architectural instruction stream expected from the current fetch target
   typedef struct packed {
      logic [15:0] pc2;
      logic [15:0] instr;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] m_addr;
   bit          m_end;

   task automatic model_fill();
      logic [15:0] w;
      while (exp_q.size() < 4 && !m_end) begin
         w = mem_rd(m_addr);
         exp_q.push_back('{pc2: m_addr + 16'd2, instr: w});
         if (w[15:12] == HALT_OP) m_end = 1'b1;
         m_addr = m_addr + 16'd2;
      end
   endtask

   task automatic model_restart(input logic [15:0] a);
      exp_q.delete();
      m_addr = a;
      m_end  = 1'b0;
      model_fill();
   endtask

   // Memory: a request is accepted in its first cycle and answered after lat cycles
   bit          mt_busy = 1'b0;
   bit          mt_new;
   logic [15:0] mt_addr;
   int          mt_left;

   task automatic cyc(input bit st, input bit rd, input logic [15:0] tgt, input int lat, input bit rs);
      @(negedge clk);
      rst = rs;
      #1;
      mt_new = 1'b0;
      if (!rs && !mt_busy && imem_req) begin
         mt_busy = 1'b1;
         mt_addr = imem_addr;
         mt_left = lat;
         mt_new  = 1'b1;
      end
      if (mt_busy && mt_left == 0) begin
         imem_ready = 1'b1;
         imem_data  = mem_rd(mt_addr);
      end else begin
         imem_ready = 1'b0;
         imem_data  = 16'($urandom);
      end
      stall           = st;
      redirect        = rd & ~rs;
      redirect_target = tgt;
      if (rs) model_restart(16'h0000);
      else if (rd) model_restart(tgt);
      else model_fill();
      @(posedge clk);
      // a request squashed in its own issue cycle is never accepted by memory
      if (rs || (rd && mt_new && !imem_ready)) mt_busy = 1'b0;
      else if (mt_busy) begin
         if (imem_ready) mt_busy = 1'b0;
         else mt_left = mt_left - 1;
      end
   endtask

   int          n_checks   = 0;
   int          n_errors   = 0;
   int          n_consumed = 0;
   bit          exp_halted = 1'b0;
   bit          prev_hold  = 1'b0;
   logic [15:0] prev_instr = 16'h0000;

   task automatic chk1(input string name, input logic act, input logic req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
      end
   endtask

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: samples just before each rising edge
   always @(negedge clk) begin
      exp_t        e;
      logic [15:0] nxt;
      #3;
      if (rst) begin
         chk1("rst_pc_we", pc_we, 1'b0);
         chk1("rst_imem_req", imem_req, 1'b0);
         chk1("rst_if_valid", if_valid, 1'b0);
         chk1("rst_halted", halted, 1'b0);
         exp_halted = 1'b0;
         prev_hold  = 1'b0;
      end else begin
         chk16("imem_addr", imem_addr, pc);
         chk1("halted", halted, exp_halted);
         if (exp_halted) chk1("halted_req", imem_req, 1'b0);
         if (!if_valid) chk16("idle_instr", if_instr, 16'h0000);
         if (prev_hold && !redirect) begin
            chk1("hold_valid", if_valid, 1'b1);
            chk16("hold_instr", if_instr, prev_instr);
            chk1("hold_req", imem_req, 1'b0);
         end
         if (redirect) begin
            chk1("redir_we", pc_we, 1'b1);
            chk16("redir_next", pc_next, redirect_target);
            chk1("redir_valid", if_valid, 1'b0);
            exp_halted = 1'b0;
         end else if (if_valid && !stall) begin
            n_consumed++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_delivery: got instr %h, expected none at %0t", if_instr, $time);
            end else begin
               e = exp_q.pop_front();
               chk16("instr", if_instr, e.instr);
               chk16("pc_plus2", if_pc_plus2, e.pc2);
               if (e.instr[15:12] == HALT_OP) begin
                  chk1("hlt_we", pc_we, 1'b0);
                  exp_halted = 1'b1;
               end else begin
                  nxt = pc + 16'd2;
                  chk1("seq_we", pc_we, 1'b1);
                  chk16("seq_next", pc_next, nxt);
               end
            end
         end else begin
            chk1("idle_we", pc_we, 1'b0);
         end
         prev_hold  = if_valid && stall && !redirect;
         prev_instr = if_instr;
      end
   end

   initial begin
      logic [15:0] w;
      for (int i = 0; i < 32768; i++) begin
         w = 16'($urandom);
         if (w[15:12] == HALT_OP && $urandom_range(0, 15) != 0) w[15:12] = 4'h1;
         if (i < 512 || i == 32767) w[15:12] = w[15:12] & 4'h7;
         mem[i] = w;
      end
      mem[0]        = 16'h1234;
      mem[1]        = 16'h5678;
      mem[16'h000B] = 16'hA5A5;
      mem[16'h0010] = 16'hF000;

      repeat (3) cyc(1'b0, 1'b0, 16'h0000, 0, 1'b1);
      repeat (6) cyc(1'b0, 1'b0, 16'h0000, 0, 1'b0);
      // three-cycle memory latency
      cyc(1'b0, 1'b1, 16'h0010, 2, 1'b0);
      repeat (8) cyc(1'b0, 1'b0, 16'h0000, 2, 1'b0);
      // stall on a hit, then release
      cyc(1'b1, 1'b0, 16'h0000, 0, 1'b0);
      cyc(1'b1, 1'b0, 16'h0000, 0, 1'b0);
      repeat (3) cyc(1'b0, 1'b0, 16'h0000, 0, 1'b0);
      // redirect while waiting; late response must be drained
      cyc(1'b0, 1'b1, 16'h0080, 3, 1'b0);
      cyc(1'b0, 1'b0, 16'h0000, 3, 1'b0);
      cyc(1'b0, 1'b1, 16'h0100, 3, 1'b0);
      repeat (8) cyc(1'b0, 1'b0, 16'h0000, 0, 1'b0);
      // HLT at 0x0020, then resume via redirect
      cyc(1'b0, 1'b1, 16'h001C, 0, 1'b0);
      repeat (6) cyc(1'b0, 1'b0, 16'h0000, 0, 1'b0);
      cyc(1'b0, 1'b1, 16'h0040, 0, 1'b0);
      repeat (3) cyc(1'b0, 1'b0, 16'h0000, 0, 1'b0);
      // PC wrap and stall+redirect together
      cyc(1'b0, 1'b1, 16'hFFFE, 0, 1'b0);
      repeat (3) cyc(1'b0, 1'b0, 16'h0000, 0, 1'b0);
      cyc(1'b1, 1'b1, 16'h0200, 0, 1'b0);
      repeat (2) cyc(1'b0, 1'b0, 16'h0000, 0, 1'b0);
      // reset in the middle of a slow fetch
      cyc(1'b0, 1'b0, 16'h0000, 1, 1'b0);
      cyc(1'b0, 1'b0, 16'h0000, 1, 1'b0);
      cyc(1'b0, 1'b0, 16'h0000, 0, 1'b1);
      repeat (3) cyc(1'b0, 1'b0, 16'h0000, 0, 1'b0);

      for (int k = 0; k < 4000; k++) begin
         cyc($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
             16'($urandom) & 16'hFFFE, int'($urandom_range(0, 3)),
             $urandom_range(0, 399) == 0);
      end

      @(negedge clk);
      #5;
      n_checks++;
      if (n_consumed < 200) begin
         n_errors++;
         $display("FAIL progress: got %0d deliveries, expected at least 200", n_consumed);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Next-PC and instruction-fetch controller for the 16-bit pipelined core. It sits directly upstream of the PC register: it reads the current PC (Q) and drives the PC register's D and WriteReg. It also runs the instruction-memory request/ready handshake and presents fetched instructions to the IF/ID pipeline register. It absorbs variable memory latency, hazard stalls, branch redirects and HLT.

Parameters:
ADDR_W, 16, PC and instruction-memory address width
INSTR_W, 16, instruction width
PC_INC, 2, byte increment per sequential fetch
HALT_OP, 4'hF, opcode in instr[15:12] that halts fetch

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
pc  in  ADDR_W  current PC (PC register Q)
pc_next  out  ADDR_W  value for PC register D
pc_we  out  1  PC register WriteReg
imem_req  out  1  instruction-memory request
imem_addr  out  ADDR_W  request address
imem_ready  in  1  memory has data this cycle (may arrive in the same cycle as req)
imem_data  in  INSTR_W  returned instruction, valid only when imem_ready=1
stall  in  1  hazard unit: IF/ID must hold, do not consume
redirect  in  1  taken branch/jump resolved in ID
redirect_target  in  ADDR_W  redirect destination
if_valid  out  1  if_instr/if_pc_plus2 valid for IF/ID
if_instr  out  INSTR_W  fetched instruction (0x0000 when if_valid=0)
if_pc_plus2  out  ADDR_W  address of fetched instruction + PC_INC
halted  out  1  fetch stopped on HLT

Behaviour:
- States: FETCH, WAIT, HOLD, DRAIN, HALTED. Reset -> FETCH. buf_valid=0, instr_buf=0.
- Outputs during and immediately after rst: pc_we=0, imem_req=0, if_valid=0, halted=0. The PC register resets itself to 0x0000.
- imem_addr = pc at all times. pc_next defaults to pc + PC_INC (mod 2^16; 0xFFFE wraps to 0x0000).
- FETCH: imem_req=1.
  - If imem_ready=1: if_valid=1, if_instr=imem_data.
    - !stall: pc_we=1, stay in FETCH. Zero-bubble throughput on hits.
    - stall: capture the data into instr_buf, go to HOLD, pc_we=0.
  - If imem_ready=0: go to WAIT.
- WAIT: imem_req=1, if_valid=0.
  - On imem_ready: behave exactly as the FETCH hit case (deliver, or buffer to HOLD).
- HOLD: imem_req=0, if_valid=1, if_instr=instr_buf, pc_we=0.
  - When stall drops: pc_we=1, then FETCH.
- HLT: when the delivered instruction has [15:12]==HALT_OP and is consumed (!stall):
  - pc_we=0, so the PC stays at the HLT address and if_pc_plus2 = pc + 2.
  - Go to HALTED.
- HALTED: halted=1, imem_req=0, if_valid=0, pc_we=0.
- Redirect has highest priority in every state:
  - Drives pc_next=redirect_target, pc_we=1 and if_valid=0 that cycle; the current fetch is squashed and buf_valid is cleared.
  - In WAIT with the response not yet returned: go to DRAIN, where imem_req=0 and the next imem_ready is discarded, then go to FETCH.
  - In FETCH, HOLD or HALTED: go to FETCH. A speculative HLT is cancelled by an older branch.
- stall and redirect in the same cycle: redirect wins (pc_we=1).
- rst mid-WAIT or mid-DRAIN: go to FETCH and ignore any late imem_ready in the reset cycle.
- if_pc_plus2 is computed from pc (the address of the delivered instruction), which is unchanged until pc_we.

Decomposition:
- Shared cpu package holds: ADDR_W, INSTR_W, PC_INC, the HALT_OP opcode constant, and the fetch state enum (FETCH/WAIT/HOLD/DRAIN/HALTED), reused by the hazard unit and trace monitors.
- Optional sub-module fetch_buf: a one-entry instruction holding register with load/clear.
- PC adder stays inline.

Test Plan:
- Reset, then pc=0x0000, imem_ready tied 1, data 0x1234/0x5678 -> pc_we=1 each cycle; pc_next 0x0002, 0x0004; if_valid=1 each cycle with if_pc_plus2 0x0002, 0x0004.
- Memory latency 3 cycles at pc=0x0010 -> imem_req held, if_valid=0 for 2 cycles; on ready, if_valid=1 and pc_next=0x0012.
- stall high for 2 cycles coincident with a hit returning 0xA5A5 -> HOLD: if_instr=0xA5A5 stable, pc_we=0, imem_req=0; stall drop -> pc_we=1, pc_next=pc+2.
- redirect to 0x0100 while in WAIT -> pc_we=1, pc_next=0x0100, if_valid=0; late imem_ready in DRAIN dropped; next fetch addr 0x0100.
- HLT 0xF000 at pc=0x0020 -> delivered once, then halted=1, pc stays 0x0020, imem_req=0; subsequent redirect to 0x0040 -> halted=0, fetch resumes at 0x0040.
- pc=0xFFFE hit, no stall -> pc_next=0x0000; stall+redirect same cycle -> pc_next=redirect_target.
